// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, instruction field positions, fetch FSM states
// and small arithmetic helpers used by the fetch stage and its optional counters.
package mips_pkg;

  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADD_IMM = 6'h08;

  // sll $0,$0,0 encodes as all zeros.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch-stage event counters; instantiated only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic        waiting,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] wait_cycles
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      wait_cycles  <= '0;
    end else begin
      if (stall)    stall_cycles <= sat_inc(stall_cycles);
      if (redirect) flush_count  <= sat_inc(flush_count);
      if (waiting)  wait_cycles  <= sat_inc(wait_cycles);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register of the 5-stage MIPS core: owns the PC, fetches over a req/ack
// handshake and honours stall/redirect. Define FETCH_PERF_CNT_EN to add performance counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifidir,
  output logic [31:0] ifidpc4,
  output logic        ifid_valid,
  output logic [5:0]  ifop,
  output logic [4:0]  ifidrs,
  output logic [4:0]  ifidrt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] wait_cycles
`endif
);

  fetch_state_t state, state_next;
  logic        req_en;
  logic [31:0] pc, pc_next;
  logic [31:0] pending, pending_next;
  logic [31:0] buffer, buffer_next;
  logic [31:0] ir_next, pc4_next;
  logic        valid_next;
  logic [31:0] target;

  assign target = word_align(redirect_pc);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  // Requests are held off until the first edge after reset releases.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) req_en <= 1'b0;
    else          req_en <= 1'b1;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_next   = state;
    pc_next      = pc;
    pending_next = pending;
    buffer_next  = buffer;
    ir_next      = ifidir;
    pc4_next     = ifidpc4;
    valid_next   = ifid_valid;
    if (req_en) begin
      if (redirect) begin
        ir_next     = NOP_INSTR;
        valid_next  = 1'b0;
        buffer_next = '0;
        if (state != HOLD && !imem_ack) begin
          pending_next = target;
          state_next   = DROP;
        end else begin
          pc_next    = target;
          state_next = FETCH;
        end
      end else begin
        unique case (state)
          FETCH: begin
            if (imem_ack && !stall) begin
              ir_next    = imem_rdata;
              pc4_next   = pc + 32'd4;
              valid_next = 1'b1;
              pc_next    = pc + 32'd4;
            end else if (imem_ack) begin
              buffer_next = imem_rdata;
              state_next  = HOLD;
            end else if (!stall) begin
              // ID consumed its entry while nothing new arrived.
              ir_next    = NOP_INSTR;
              valid_next = 1'b0;
            end
          end
          HOLD: begin
            if (!stall) begin
              ir_next    = buffer;
              pc4_next   = pc + 32'd4;
              valid_next = 1'b1;
              pc_next    = pc + 32'd4;
              state_next = FETCH;
            end
          end
          DROP: begin
            ir_next    = NOP_INSTR;
            valid_next = 1'b0;
            if (imem_ack) begin
              pc_next    = pending;
              state_next = FETCH;
            end
          end
          default: state_next = FETCH;
        endcase
      end
    end
  end

  always_comb begin
    imem_req  = req_en && (state != HOLD);
    imem_addr = pc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      pending    <= '0;
      buffer     <= '0;
      ifidir     <= NOP_INSTR;
      ifidpc4    <= '0;
      ifid_valid <= 1'b0;
    end else begin
      pc         <= pc_next;
      pending    <= pending_next;
      buffer     <= buffer_next;
      ifidir     <= ir_next;
      ifidpc4    <= pc4_next;
      ifid_valid <= valid_next;
    end
  end

  assign ifop   = ifidir[OP_MSB:OP_LSB];
  assign ifidrs = ifidir[RS_MSB:RS_LSB];
  assign ifidrt = ifidir[RT_MSB:RT_LSB];

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clock        (clock),
    .reset_n      (reset_n),
    .stall        (stall),
    .redirect     (redirect),
    .waiting      (imem_req && !imem_ack),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .wait_cycles  (wait_cycles)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations plus a
// transaction-level reference model compared every cycle.
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ifidir;
  logic [31:0] ifidpc4;
  logic        ifid_valid;
  logic [5:0]  ifop;
  logic [4:0]  ifidrs;
  logic [4:0]  ifidrt;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, wait_cycles;
`endif

  fetch_stage dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ifidir      (ifidir),
    .ifidpc4     (ifidpc4),
    .ifid_valid  (ifid_valid),
    .ifop        (ifop),
    .ifidrs      (ifidrs),
    .ifidrt      (ifidrt)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .wait_cycles  (wait_cycles)
`endif
  );

  initial forever #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [5:0] op;
    if (a == 32'h20) return 32'h8C41_0004;
    case (a[3:2])
      2'd0:    op = OP_ADD_IMM;
      2'd1:    op = OP_BEQ;
      2'd2:    op = OP_J;
      default: op = OP_JAL;
    endcase
    return {op, a[6:2], a[11:7], a[15:0]};
  endfunction

  // Memory responder: acks once a request has waited `lat` cycles.
  int lat = 0;
  initial begin
    int cnt = 0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clock);
      #2;
      imem_rdata = mem(imem_addr);
      if (!imem_req) begin
        imem_ack = 1'b0;
        cnt = 0;
      end else if (cnt >= lat) begin
        imem_ack = 1'b1;
        cnt = 0;
      end else begin
        imem_ack = 1'b0;
        cnt++;
      end
    end
  end

  // Reference model: a fetch is outstanding unless an instruction is parked in `held`;
  // `discarding` marks an outstanding fetch whose data must be thrown away.
  bit          m_live;
  bit          discarding;
  logic [31:0] m_pc, m_target, m_ir, m_pc4;
  bit          m_v;
  logic [31:0] held[$];
  logic [31:0] m_stall_c, m_flush_c, m_wait_c;

  task automatic model_reset();
    m_live = 0; discarding = 0; m_pc = 32'h0; m_target = 32'h0;
    m_ir = 32'h0; m_pc4 = 32'h0; m_v = 0; held.delete();
    m_stall_c = 0; m_flush_c = 0; m_wait_c = 0;
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_step(input bit s, input bit r, input logic [31:0] rpc,
                            input bit a, input logic [31:0] d);
    bit requesting;
    requesting = m_live && (held.size() == 0);
    if (s) m_stall_c = sat(m_stall_c);
    if (r) m_flush_c = sat(m_flush_c);
    if (requesting && !a) m_wait_c = sat(m_wait_c);
    if (!m_live) begin
      m_live = 1;
      return;
    end
    if (r) begin
      m_ir = 32'h0; m_v = 0;
      if (held.size() != 0) begin
        held.delete();
        m_pc = rpc & ~32'h3;
      end else if (a) begin
        discarding = 0;
        m_pc = rpc & ~32'h3;
      end else begin
        discarding = 1;
        m_target = rpc & ~32'h3;
      end
    end else if (held.size() != 0) begin
      if (!s) begin
        m_ir = held.pop_front(); m_pc4 = m_pc + 4; m_v = 1; m_pc = m_pc + 4;
      end
    end else if (discarding) begin
      m_ir = 32'h0; m_v = 0;
      if (a) begin
        discarding = 0;
        m_pc = m_target;
      end
    end else if (a) begin
      if (s) held.push_back(d);
      else begin
        m_ir = d; m_pc4 = m_pc + 4; m_v = 1; m_pc = m_pc + 4;
      end
    end else if (!s) begin
      m_ir = 32'h0; m_v = 0;
    end
  endtask

  initial begin
    bit exp_req;
    model_reset();
    forever begin
      @(posedge clock);
      if (!reset_n) model_reset();
      else model_step(stall, redirect, redirect_pc, imem_ack, imem_rdata);
      exp_req = m_live && (held.size() == 0);
      #1;
      check("model_req", imem_req, exp_req);
      if (exp_req) check("model_addr", imem_addr, m_pc);
      check("model_ir", ifidir, m_ir);
      check("model_valid", ifid_valid, m_v);
      if (m_v) check("model_pc4", ifidpc4, m_pc4);
      check("model_fields", {ifop, ifidrs, ifidrt}, {m_ir[31:26], m_ir[25:21], m_ir[20:16]});
`ifdef FETCH_PERF_CNT_EN
      check("model_stall_cycles", stall_cycles, m_stall_c);
      check("model_flush_count", flush_count, m_flush_c);
      check("model_wait_cycles", wait_cycles, m_wait_c);
`endif
    end
  end

  task automatic nxt();
    @(negedge clock);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_ir"}, ifidir, 32'h0);
    check({tag, "_valid"}, ifid_valid, 1'b0);
    check({tag, "_pc4"}, ifidpc4, 32'h0);
    check({tag, "_ifop"}, ifop, 6'h0);
`ifdef FETCH_PERF_CNT_EN
    check({tag, "_cnt"}, stall_cycles | flush_count | wait_cycles, 32'h0);
`endif
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    nxt();
    check_reset_state("reset");
    nxt();
    reset_n = 1'b1;

    // Zero-wait streaming from reset.
    nxt();
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      nxt();
      check("stream_pc4", ifidpc4, 32'(4 * i));
      check("stream_valid", ifid_valid, 1'b1);
    end
    check("stream_addr", imem_addr, 32'h10);
    lat = 3;

    // Three wait states at pc=0x10.
    for (int i = 0; i < 3; i++) begin
      nxt();
      check("wait_bubble", ifid_valid, 1'b0);
    end
    nxt();
    check("wait_pc4", ifidpc4, 32'h14);
    check("wait_ir", ifidir, mem(32'h10));
    lat = 0;

    // Stall while the ack for pc=0x20 arrives.
    nxt(); nxt(); nxt();
    check("stall_addr", imem_addr, 32'h20);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      nxt();
      check("stall_req", imem_req, 1'b0);
      check("stall_ir_hold", ifidir, mem(32'h1C));
    end
    stall = 1'b0;
    nxt();
    check("release_ir", ifidir, 32'h8C41_0004);
    check("release_ifop", ifop, OP_LW);
    check("release_rs", ifidrs, 5'd2);
    check("release_rt", ifidrt, 5'd1);
    check("release_pc4", ifidpc4, 32'h24);

    // Redirect to 0x103 while the fetch of 0x40 waits.
    repeat (7) nxt();
    check("drop_addr0", imem_addr, 32'h40);
    lat = 4;
    nxt();
    redirect = 1'b1; redirect_pc = 32'h103;
    nxt();
    redirect = 1'b0;
    check("drop_req", imem_req, 1'b1);
    check("drop_addr1", imem_addr, 32'h40);
    check("drop_valid1", ifid_valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      nxt();
      check("drop_addr", imem_addr, 32'h40);
      check("drop_valid", ifid_valid, 1'b0);
    end
    nxt();
    check("drop_target", imem_addr, 32'h100);
    check("drop_valid_end", ifid_valid, 1'b0);
    lat = 0;
    nxt();
    check("target_pc4", ifidpc4, 32'h104);
    check("target_ir", ifidir, mem(32'h100));

    // Stall and redirect together: redirect wins.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    nxt();
    stall = 1'b0; redirect = 1'b0;
    check("sr_valid", ifid_valid, 1'b0);
    check("sr_ir", ifidir, NOP_INSTR_DEFAULT);
    check("sr_addr", imem_addr, 32'h200);
    nxt();
    check("sr_pc4", ifidpc4, 32'h204);

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    nxt();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    nxt();
    check("wrap_pc4", ifidpc4, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);
    lat = 3;

    // Reset asserted in the middle of a wait.
    nxt();
    #3 reset_n = 1'b0;
    #1 check_reset_state("midreset");
    nxt();
    nxt();
    reset_n = 1'b1;
    nxt();
    check("rerun_req", imem_req, 1'b1);
    check("rerun_addr", imem_addr, 32'h0);
    lat = 0;
    nxt();
    check("rerun_pc4", ifidpc4, 32'h4);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS core. Sits directly upstream of the interlock unit.
- Owns the PC and fetches instructions over a req/ack instruction-memory handshake.
- Presents the IF/ID instruction and its decoded op/rs/rt fields to the interlock and ID stage.
- Honours the interlock stall and branch/jump redirects from ID/EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0) inserted on flush or empty fetch.

Ports:
- clock  in  1  core clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  interlock stall; holds PC and IF/ID.
- redirect  in  1  taken branch or jump from ID/EX.
- redirect_pc  in  32  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- ifidir  out  32  IF/ID instruction.
- ifidpc4  out  32  IF/ID PC+4.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifop  out  6  ifidir[31:26].
- ifidrs  out  5  ifidir[25:21].
- ifidrt  out  5  ifidir[20:16].

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_PC, ifidir=NOP_INSTR, ifidpc4=0, ifid_valid=0.
  - Buffer cleared, state=FETCH, imem_req=0.
  - imem_req rises on the first clock edge after reset_n deasserts.
  - A request abandoned by reset is never consumed.
- Handshake:
  - imem_addr=pc while imem_req=1. It is stable until imem_ack.
  - imem_ack is sampled at posedge and is only meaningful while imem_req=1.
  - Wait states are unbounded. The minimum latency is a same-cycle ack.
- FSM states: FETCH, HOLD, DROP.
- FETCH (imem_req=1):
  - ack && !stall: IF/ID<= {rdata, pc+4, valid=1}; pc<=pc+4.
  - ack && stall: buffer<=rdata; IF/ID unchanged; ->HOLD.
  - !ack && !stall: IF/ID<=bubble (NOP_INSTR, valid=0), because ID consumed its entry.
  - !ack && stall: IF/ID unchanged.
- HOLD (imem_req=0):
  - stall=1: wait.
  - stall=0: IF/ID<= {buffer, pc+4, 1}; pc<=pc+4; ->FETCH.
- DROP (imem_req=1, address of the discarded fetch still driven):
  - Wait for ack and discard the data.
  - On ack: pc<=pending target; ->FETCH.
  - IF/ID stays bubble throughout.
- Redirect has priority over stall and over ack. Same cycle:
  - IF/ID<=bubble; buffer invalidated.
  - Target is taken as redirect_pc with bits [1:0] forced to 0.
  - FETCH with ack, or HOLD: pc<=target; ->FETCH.
  - FETCH without ack: pending<=target; ->DROP.
  - DROP: pending<=target (newest wins); stay in DROP, or ->FETCH if ack arrives.
- PC wrap: pc+4 wraps modulo 2^32 with no flag.
- ifop/ifidrs/ifidrt are purely combinational slices of ifidir. They are 0 while a bubble is held.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output ports stall_cycles[31:0], flush_count[31:0], wait_cycles[31:0]. All reset to 0 and saturate at all-ones.
  - stall_cycles increments every cycle stall=1.
  - flush_count increments per redirect cycle.
  - wait_cycles increments on cycles in FETCH/DROP with imem_req=1 and no ack.
- Undefined: no ports and no logic. Behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (LW, BEQ, J, JAL, ADD_IMM).
  - NOP_INSTR default.
  - instruction field bit ranges.
  - fetch_state_t enum {FETCH, HOLD, DROP}.
- One sub-module: fetch_perf_counters, instantiated only under FETCH_PERF_CNT_EN.

Test Plan:
- Zero-wait memory, no stall/redirect, 4 cycles from reset: ifidpc4=4,8,12,16; ifid_valid=1 from the 2nd edge.
- ack with 3 wait states at pc=0x10: IF/ID shows 3 bubbles (valid=0), then rdata with ifidpc4=0x14.
- stall high 2 cycles when ack arrives for pc=0x20 (rdata=0x8C41_0004): ifidir unchanged for 2 cycles, imem_req=0. On release ifidir=0x8C41_0004, ifop=0x23, ifidrs=2, ifidrt=1.
- redirect to 0x103 while request for pc=0x40 pending without ack:
  - ->DROP; ack data is discarded.
  - next imem_addr=0x100; IF/ID bubble throughout.
- stall and redirect in the same cycle: redirect wins; ifid_valid=0; pc=target.
- reset_n asserted mid-wait: imem_req drops immediately; outputs return to reset values. With FETCH_PERF_CNT_EN, the counters read 0.
